pid_controller: RTL and testbench

//   Discrete-time fixed-point PID controller; one control update per enabled clock cycle.

---
 rtl/pid_controller_if.sv | 15 +
 rtl/pid_controller.sv | 73 +++++++
 tb/tb_pid_controller.sv | 137 +++++++++++++
 3 files changed

// File: rtl/pid_controller_if.sv
// pid_controller_if: control inputs and registered PID outputs bundled between the source and the controller.
interface pid_controller_if #(parameter int DATA_WIDTH = 16);
    logic                           i_enable;
    logic signed [DATA_WIDTH-1:0]   i_kp, i_ki, i_kd, i_setpoint, i_process_var;
    logic signed [DATA_WIDTH-1:0]   o_control_output, o_error_out;
    logic signed [2*DATA_WIDTH-1:0] o_p_term_out, o_i_term_out, o_d_term_out;
    modport master (
        output i_enable, i_kp, i_ki, i_kd, i_setpoint, i_process_var,
        input  o_control_output, o_error_out, o_p_term_out, o_i_term_out, o_d_term_out
    );
    modport slave (
        input  i_enable, i_kp, i_ki, i_kd, i_setpoint, i_process_var,
        output o_control_output, o_error_out, o_p_term_out, o_i_term_out, o_d_term_out
    );
endinterface

// File: rtl/pid_controller.sv
// pid_controller: fixed-point PID with saturating error/integral, anti-windup hold and clamped output.
module pid_controller #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int OUTPUT_MIN = -1000,
    parameter int OUTPUT_MAX = 1000
) (
    input logic              clk,
    input logic              rst,
    pid_controller_if.slave  bus
);
    localparam int DW = DATA_WIDTH;
    localparam int SW = 2*DW+2;
    localparam logic signed [SW-1:0] L_MAX = SW'(OUTPUT_MAX);
    localparam logic signed [SW-1:0] L_MIN = SW'(OUTPUT_MIN);

    function automatic logic signed [DW-1:0] sat(input logic signed [DW:0] x);
        return (x[DW] != x[DW-1]) ? {x[DW], {(DW-1){~x[DW]}}} : x[DW-1:0];
    endfunction

    logic signed [DW-1:0]   r_integral, r_prev_error, r_out, r_err;
    logic signed [2*DW-1:0] r_p, r_i, r_d;
    logic                   r_sat_hi, r_sat_lo;

    logic signed [DW-1:0]   w_err, w_diff, w_integ, w_out;
    logic signed [2*DW-1:0] w_p, w_i, w_d;
    logic signed [SW-1:0]   w_sum, w_scaled;
    logic                   w_hold, w_hi, w_lo;

    assign w_err    = sat({bus.i_setpoint[DW-1], bus.i_setpoint} - {bus.i_process_var[DW-1], bus.i_process_var});
    assign w_diff   = sat({w_err[DW-1], w_err} - {r_prev_error[DW-1], r_prev_error});
    // Freeze the integrator while the last output was pinned and the error pushes further into the rail.
    assign w_hold   = (r_sat_hi && !w_err[DW-1] && w_err != '0) || (r_sat_lo && w_err[DW-1]);
    assign w_integ  = w_hold ? r_integral : sat({r_integral[DW-1], r_integral} + {w_err[DW-1], w_err});
    assign w_p      = bus.i_kp * w_err;
    assign w_i      = bus.i_ki * w_integ;
    assign w_d      = bus.i_kd * w_diff;
    assign w_sum    = SW'(w_p) + SW'(w_i) + SW'(w_d);
    assign w_scaled = w_sum >>> FRAC_BITS;
    assign w_hi     = w_scaled > L_MAX;
    assign w_lo     = w_scaled < L_MIN;
    assign w_out    = w_hi ? L_MAX[DW-1:0] : w_lo ? L_MIN[DW-1:0] : w_scaled[DW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_integral   <= '0;
            r_prev_error <= '0;
            r_out        <= '0;
            r_err        <= '0;
            r_p          <= '0;
            r_i          <= '0;
            r_d          <= '0;
            r_sat_hi     <= 1'b0;
            r_sat_lo     <= 1'b0;
        end else if (bus.i_enable) begin
            r_integral   <= w_integ;
            r_prev_error <= w_err;
            r_out        <= w_out;
            r_err        <= w_err;
            r_p          <= w_p;
            r_i          <= w_i;
            r_d          <= w_d;
            r_sat_hi     <= w_hi;
            r_sat_lo     <= w_lo;
        end
    end

    assign bus.o_control_output = r_out;
    assign bus.o_error_out      = r_err;
    assign bus.o_p_term_out     = r_p;
    assign bus.o_i_term_out     = r_i;
    assign bus.o_d_term_out     = r_d;
endmodule

// File: tb/tb_pid_controller.sv
// tb_pid_controller: directed and random steps against a behavioural integer PID model via an expectation queue.
module tb_pid_controller;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pid_controller_if #(.DATA_WIDTH(16)) bus();
    pid_controller dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {longint out; longint err; longint p; longint i; longint d;} exp_t;
    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;
    longint kp = 0, ki = 0, kd = 0;
    longint m_int = 0, m_prev = 0, m_out = 0, m_err = 0, m_p = 0, m_i = 0, m_d = 0;
    bit m_hi = 0, m_lo = 0;

    function automatic longint sat16(longint x);
        return x > 32767 ? 32767 : (x < -32768 ? -32768 : x);
    endfunction

    task automatic check(string tag, logic signed [63:0] obs, logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(bit r, bit en, int sp, int pv);
        exp_t e;
        longint err, diff, integ, sum, sc;
        bit hold;
        rst = r;
        bus.i_enable = en;
        bus.i_setpoint = 16'(sp);
        bus.i_process_var = 16'(pv);
        bus.i_kp = 16'(kp);
        bus.i_ki = 16'(ki);
        bus.i_kd = 16'(kd);
        if (r) begin
            m_int = 0; m_prev = 0; m_out = 0; m_err = 0; m_p = 0; m_i = 0; m_d = 0; m_hi = 0; m_lo = 0;
        end else if (en) begin
            err   = sat16(longint'(sp) - pv);
            diff  = sat16(err - m_prev);
            hold  = (m_hi && err > 0) || (m_lo && err < 0);
            integ = hold ? m_int : sat16(m_int + err);
            m_p = kp * err;
            m_i = ki * integ;
            m_d = kd * diff;
            sum = m_p + m_i + m_d;
            sc  = sum / 256;
            if (sum < 0 && sum % 256 != 0) sc = sc - 1;
            m_hi  = sc > 1000;
            m_lo  = sc < -1000;
            m_out = m_hi ? 1000 : (m_lo ? -1000 : sc);
            m_err = err; m_prev = err; m_int = integ;
        end
        e = '{m_out, m_err, m_p, m_i, m_d};
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        check("control_output", $signed(bus.o_control_output), e.out);
        check("error_out", $signed(bus.o_error_out), e.err);
        check("p_term", $signed(bus.o_p_term_out), e.p);
        check("i_term", $signed(bus.o_i_term_out), e.i);
        check("d_term", $signed(bus.o_d_term_out), e.d);
    endtask

    initial begin
        kp = 256; ki = 64; kd = 128;
        step(1, 0, 0, 0);
        step(1, 1, 100, 0);
        check("reset_priority_out", $signed(bus.o_control_output), 0);
        step(0, 1, 100, 0);
        check("c1_out", $signed(bus.o_control_output), 175);
        check("c1_p", $signed(bus.o_p_term_out), 25600);
        check("c1_i", $signed(bus.o_i_term_out), 6400);
        check("c1_d", $signed(bus.o_d_term_out), 12800);
        step(0, 1, 100, 0);
        check("c2_out", $signed(bus.o_control_output), 150);
        check("c2_i", $signed(bus.o_i_term_out), 12800);
        check("c2_d", $signed(bus.o_d_term_out), 0);
        step(0, 1, 100, 40);
        step(0, 1, 100, 80);
        repeat (5) step(0, 0, 999, -999);
        step(0, 1, 100, 90);
        step(1, 1, 100, 0);
        check("midrun_reset_out", $signed(bus.o_control_output), 0);
        step(0, 1, 100, 0);
        check("kick_d", $signed(bus.o_d_term_out), 12800);

        kp = 256; ki = 0; kd = 0;
        step(1, 0, 0, 0);
        step(0, 1, 2000, 0);
        check("clamp_hi_out", $signed(bus.o_control_output), 1000);
        ki = 64;
        step(0, 1, 2000, 0);
        check("windup_i_a", $signed(bus.o_i_term_out), 128000);
        step(0, 1, 2000, 0);
        check("windup_i_b", $signed(bus.o_i_term_out), 128000);

        kp = 256; ki = 64; kd = 0;
        step(1, 0, 0, 0);
        repeat (3) step(0, 1, -2000, 0);
        step(0, 1, -2000, -2100);
        step(0, 1, -2000, -1000);

        kp = 256; ki = 0; kd = 0;
        step(1, 0, 0, 0);
        step(0, 1, -150, 0);
        check("neg_out", $signed(bus.o_control_output), -150);
        kp = 128;
        step(1, 0, 0, 0);
        step(0, 1, -3, 0);
        check("floor_p", $signed(bus.o_p_term_out), -384);
        check("floor_out", $signed(bus.o_control_output), -2);
        step(0, 1, 32767, -32768);
        check("err_sat_pos", $signed(bus.o_error_out), 32767);
        step(0, 1, -32768, 32767);
        check("err_sat_neg", $signed(bus.o_error_out), -32768);

        step(1, 0, 0, 0);
        for (int n = 0; n < 60; n++) begin
            kp = longint'(int'($urandom_range(0, 2048)) - 1024);
            ki = longint'(int'($urandom_range(0, 512)) - 256);
            kd = longint'(int'($urandom_range(0, 1024)) - 512);
            step(0, $urandom_range(0, 4) != 0,
                 int'($urandom_range(0, 65535)) - 32768,
                 int'($urandom_range(0, 65535)) - 32768);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
